// File: rtl/scaler_cfg_ctrl.sv
// Scaler configuration controller: host shadow registers, validated commit, vsync-aligned load.
// Optional frame counter enabled by defining SCALER_CFG_CTRL_FRAME_CNT_EN.
module scaler_cfg_ctrl #(
   parameter int LINE_IN_SIZE_MAX = 1024,
   parameter int SCALE_STEP       = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_wr,
   input  logic [1:0]  cfg_adr,
   input  logic [15:0] cfg_data,
   input  logic        vs_i,
   output logic [15:0] reg_h_scale_step,
   output logic [15:0] reg_v_scale_step,
   output logic [15:0] reg_v_scale_inline_size,
   output logic        cfg_busy,
   output logic        cfg_err,
   output logic        cfg_upd,
   output logic [15:0] frame_cnt
);

   localparam logic [15:0] STEP_INIT = 16'(SCALE_STEP);
   localparam logic [15:0] SIZE_INIT = 16'(LINE_IN_SIZE_MAX);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      APPLIED = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] h_shadow;
   logic [15:0] v_shadow;
   logic [15:0] size_shadow;
   logic        vs_q;
   logic        vs_rise;
   logic        commit;
   logic        commit_ok;
   logic        load;

   assign vs_rise   = vs_i & ~vs_q;
   assign commit    = cfg_wr && (cfg_adr == 2'd3);
   assign commit_ok = (h_shadow != 16'd0) && (v_shadow != 16'd0) &&
                      (size_shadow != 16'd0) && (size_shadow <= SIZE_INIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         vs_q  <= 1'b0;
      end else begin
         state <= state_next;
         vs_q  <= vs_i;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (commit && commit_ok)
               state_next = PENDING;
         end
         PENDING: begin
            if (vs_rise) begin
               load       = 1'b1;
               state_next = APPLIED;
            end
         end
         APPLIED: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Host writes only land while no commit is outstanding
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_shadow    <= STEP_INIT;
         v_shadow    <= STEP_INIT;
         size_shadow <= SIZE_INIT;
      end else if (cfg_wr && (state == IDLE)) begin
         case (cfg_adr)
            2'd0:    h_shadow    <= cfg_data;
            2'd1:    v_shadow    <= cfg_data;
            2'd2:    size_shadow <= cfg_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_h_scale_step        <= STEP_INIT;
         reg_v_scale_step        <= STEP_INIT;
         reg_v_scale_inline_size <= SIZE_INIT;
      end else if (load) begin
         reg_h_scale_step        <= h_shadow;
         reg_v_scale_step        <= v_shadow;
         reg_v_scale_inline_size <= size_shadow;
      end
   end

   // Error is sticky until the next accepted commit
   always_ff @(posedge clk) begin
      if (!rst_n)
         cfg_err <= 1'b0;
      else if (commit && (state == IDLE))
         cfg_err <= ~commit_ok;
   end

   assign cfg_busy = (state != IDLE);
   assign cfg_upd  = (state == APPLIED);

`ifdef SCALER_CFG_CTRL_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         frame_cnt <= 16'd0;
      else if (vs_rise)
         frame_cnt <= frame_cnt + 16'd1;
   end
`else
   assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// Self-checking bench for scaler_cfg_ctrl: expected loads are queued at commit time
// and popped by a monitor whenever cfg_upd is seen.
module tb_scaler_cfg_ctrl;

   typedef struct {
      logic [15:0] h;
      logic [15:0] v;
      logic [15:0] size;
   } load_t;

   logic        clk;
   logic        rst_n;
   logic        cfg_wr;
   logic [1:0]  cfg_adr;
   logic [15:0] cfg_data;
   logic        vs_i;
   logic [15:0] reg_h_scale_step;
   logic [15:0] reg_v_scale_step;
   logic [15:0] reg_v_scale_inline_size;
   logic        cfg_busy;
   logic        cfg_err;
   logic        cfg_upd;
   logic [15:0] frame_cnt;

   load_t sb_queue[$];
   int    pass_count;
   int    check_count;
   int    upd_count;

   scaler_cfg_ctrl #(
      .LINE_IN_SIZE_MAX(1024),
      .SCALE_STEP(4096)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cfg_wr(cfg_wr),
      .cfg_adr(cfg_adr),
      .cfg_data(cfg_data),
      .vs_i(vs_i),
      .reg_h_scale_step(reg_h_scale_step),
      .reg_v_scale_step(reg_v_scale_step),
      .reg_v_scale_inline_size(reg_v_scale_inline_size),
      .cfg_busy(cfg_busy),
      .cfg_err(cfg_err),
      .cfg_upd(cfg_upd),
      .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected)
         pass_count++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] adr, input logic [15:0] data);
      cfg_wr   = 1'b1;
      cfg_adr  = adr;
      cfg_data = data;
      tick();
      cfg_wr   = 1'b0;
      cfg_data = 16'd0;
   endtask

   task automatic vsPulse();
      vs_i = 1'b1;
      tick();
      vs_i = 1'b0;
      tick();
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic checkActive(input string tag, input logic [15:0] h, input logic [15:0] v, input logic [15:0] size);
      checkOutput({tag, "_h"}, 32'(reg_h_scale_step), 32'(h));
      checkOutput({tag, "_v"}, 32'(reg_v_scale_step), 32'(v));
      checkOutput({tag, "_size"}, 32'(reg_v_scale_inline_size), 32'(size));
   endtask

   // Scoreboard monitor: every update pulse must match the oldest queued load
   always @(negedge clk) begin
      if (rst_n && cfg_upd) begin
         load_t exp_load;
         upd_count++;
         if (sb_queue.size() == 0) begin
            checkOutput("sb_unexpected_upd", 32'd1, 32'd0);
         end else begin
            exp_load = sb_queue.pop_front();
            checkOutput("sb_h", 32'(reg_h_scale_step), 32'(exp_load.h));
            checkOutput("sb_v", 32'(reg_v_scale_step), 32'(exp_load.v));
            checkOutput("sb_size", 32'(reg_v_scale_inline_size), 32'(exp_load.size));
         end
      end
   end

   initial begin
      int upd_before;
      pass_count  = 0;
      check_count = 0;
      upd_count   = 0;
      rst_n    = 1'b0;
      cfg_wr   = 1'b0;
      cfg_adr  = 2'd0;
      cfg_data = 16'd0;
      vs_i     = 1'b0;

      doReset();
      tick();
      checkActive("reset", 16'd4096, 16'd4096, 16'd1024);
      checkOutput("reset_busy", 32'(cfg_busy), 32'd0);
      checkOutput("reset_err", 32'(cfg_err), 32'd0);
      checkOutput("reset_upd", 32'(cfg_upd), 32'd0);
      checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);

      // Basic commit followed by a vsync rise held high for several cycles
      applyStimulus(2'd0, 16'd2048);
      applyStimulus(2'd1, 16'd8192);
      applyStimulus(2'd2, 16'd640);
      applyStimulus(2'd3, 16'd0);
      sb_queue.push_back('{h: 16'd2048, v: 16'd8192, size: 16'd640});
      checkOutput("pend_busy", 32'(cfg_busy), 32'd1);
      tick();
      tick();
      checkOutput("pend_busy_hold", 32'(cfg_busy), 32'd1);
      checkActive("pend_unchanged", 16'd4096, 16'd4096, 16'd1024);
      upd_before = upd_count;
      vs_i = 1'b1;
      tick();
      checkActive("load_latency", 16'd2048, 16'd8192, 16'd640);
      checkOutput("applied_upd", 32'(cfg_upd), 32'd1);
      checkOutput("applied_busy", 32'(cfg_busy), 32'd1);
      tick();
      checkOutput("post_upd", 32'(cfg_upd), 32'd0);
      checkOutput("post_busy", 32'(cfg_busy), 32'd0);
      tick();
      tick();
      vs_i = 1'b0;
      tick();
      checkOutput("upd_once", 32'(upd_count - upd_before), 32'd1);

      // Out-of-range line length is rejected and leaves outputs alone
      applyStimulus(2'd2, 16'd1025);
      applyStimulus(2'd3, 16'd0);
      checkOutput("bad_size_err", 32'(cfg_err), 32'd1);
      checkOutput("bad_size_busy", 32'(cfg_busy), 32'd0);
      vsPulse();
      checkActive("bad_size_hold", 16'd2048, 16'd8192, 16'd640);
      checkOutput("bad_size_err_sticky", 32'(cfg_err), 32'd1);

      applyStimulus(2'd2, 16'd320);
      applyStimulus(2'd3, 16'd0);
      sb_queue.push_back('{h: 16'd2048, v: 16'd8192, size: 16'd320});
      checkOutput("good_clears_err", 32'(cfg_err), 32'd0);
      checkOutput("good_busy", 32'(cfg_busy), 32'd1);

      // Writes and commits during PENDING are dropped silently
      applyStimulus(2'd0, 16'd100);
      applyStimulus(2'd3, 16'd0);
      checkOutput("pend_ignore_err", 32'(cfg_err), 32'd0);
      upd_before = upd_count;
      vsPulse();
      tick();
      checkActive("pend_ignore_load", 16'd2048, 16'd8192, 16'd320);
      checkOutput("pend_ignore_one_upd", 32'(upd_count - upd_before), 32'd1);

      // Zero step is also rejected
      applyStimulus(2'd1, 16'd0);
      applyStimulus(2'd3, 16'd0);
      checkOutput("zero_v_err", 32'(cfg_err), 32'd1);
      checkOutput("zero_v_busy", 32'(cfg_busy), 32'd0);

      // Commit in the same cycle as a vsync rise waits for the next rise
      applyStimulus(2'd1, 16'd512);
      cfg_wr  = 1'b1;
      cfg_adr = 2'd3;
      vs_i    = 1'b1;
      tick();
      cfg_wr = 1'b0;
      sb_queue.push_back('{h: 16'd2048, v: 16'd512, size: 16'd320});
      checkOutput("coinc_busy", 32'(cfg_busy), 32'd1);
      checkOutput("coinc_err", 32'(cfg_err), 32'd0);
      tick();
      checkOutput("coinc_no_upd", 32'(cfg_upd), 32'd0);
      checkActive("coinc_no_load", 16'd2048, 16'd8192, 16'd320);
      vs_i = 1'b0;
      tick();
      upd_before = upd_count;
      vsPulse();
      checkActive("coinc_next_load", 16'd2048, 16'd512, 16'd320);
      checkOutput("coinc_upd_once", 32'(upd_count - upd_before), 32'd1);

      // Reset while PENDING discards the commit entirely
      applyStimulus(2'd3, 16'd0);
      checkOutput("rst_pend_busy", 32'(cfg_busy), 32'd1);
      doReset();
      tick();
      checkOutput("rst_pend_busy_clr", 32'(cfg_busy), 32'd0);
      checkActive("rst_pend_defaults", 16'd4096, 16'd4096, 16'd1024);
      upd_before = upd_count;
      vsPulse();
      tick();
      checkOutput("rst_pend_no_upd", 32'(upd_count - upd_before), 32'd0);
      checkActive("rst_pend_no_load", 16'd4096, 16'd4096, 16'd1024);

`ifdef SCALER_CFG_CTRL_FRAME_CNT_EN
      checkOutput("frame_cnt_one", 32'(frame_cnt), 32'd1);
      for (int i = 0; i < 65536; i++)
         vsPulse();
      checkOutput("frame_cnt_wrap", 32'(frame_cnt), 32'd1);
`else
      checkOutput("frame_cnt_tied", 32'(frame_cnt), 32'd0);
`endif

      checkOutput("sb_drained", 32'(sb_queue.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/scaler_cfg_ctrl.md
SCALER_CFG_CTRL -- requirements
Module: scaler_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter LINE_IN_SIZE_MAX, default 1024, giving the largest legal input line length in pixels.
REQ-002 The block SHALL have parameter SCALE_STEP, default 4096, giving the unity (1:1) scale step value.
REQ-003 The block SHALL have port clk  in  1  as its single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n  in  1  as its reset, which is synchronous and active-low.
REQ-005 The block SHALL have port cfg_wr  in  1  as the host write strobe, valid for one cycle.
REQ-006 The block SHALL have port cfg_adr  in  2  as the write address: 0 = h_step, 1 = v_step, 2 = inline_size, 3 = commit (data ignored).
REQ-007 The block SHALL have port cfg_data  in  16  as the host write data.
REQ-008 The block SHALL have port vs_i  in  1  as the source vertical sync, active high.
REQ-009 The block SHALL have port reg_h_scale_step  out  16  as the active horizontal step driven to the scaler.
REQ-010 The block SHALL have port reg_v_scale_step  out  16  as the active vertical step driven to the scaler.
REQ-011 The block SHALL have port reg_v_scale_inline_size  out  16  as the active input line length driven to the scaler.
REQ-012 The block SHALL have port cfg_busy  out  1  as the commit-pending indicator.
REQ-013 The block SHALL have port cfg_err  out  1  as a sticky error flag for a rejected commit.
REQ-014 The block SHALL have port cfg_upd  out  1  as a one-cycle pulse marking that the active registers were loaded.
REQ-015 The block SHALL have port frame_cnt  out  16  as the frame counter.

Function
REQ-016 The block SHALL hold three 16-bit shadow registers, written by cfg_wr when cfg_adr is 0..2 and state is IDLE; such writes in any other state SHALL be ignored.
REQ-017 The block SHALL register vs_i into vs_q and define vs_rise = vs_i & ~vs_q.
REQ-018 The block SHALL implement states IDLE, PENDING and APPLIED.
REQ-019 A commit is cfg_wr with cfg_adr=3; a commit is valid when h_step != 0, v_step != 0, and 1 <= inline_size <= LINE_IN_SIZE_MAX.
REQ-020 In IDLE, a valid commit SHALL move the FSM to PENDING and clear cfg_err.
REQ-021 In IDLE, an invalid commit SHALL set cfg_err, stay in IDLE and leave the active registers unchanged.
REQ-022 In PENDING, on vs_rise the active outputs SHALL load the shadow values at that clock edge and the FSM SHALL move to APPLIED.
REQ-023 APPLIED SHALL last exactly one cycle, SHALL drive cfg_upd=1 and SHALL then return to IDLE.
REQ-024 cfg_busy SHALL be 1 in PENDING and APPLIED, and 0 in IDLE.
REQ-025 A commit or write arriving in PENDING or APPLIED SHALL be ignored, with no error raised.
REQ-026 A valid commit in IDLE in the same cycle as vs_rise SHALL enter PENDING without consuming that edge, so the load occurs on the next vs_rise.
REQ-027 vs_i held high over multiple cycles SHALL produce a single load.
REQ-028 Latency from vs_rise (vs_i sampled 1 while vs_q = 0) to the updated outputs SHALL be 1 clock; cfg_upd is asserted in the following cycle.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL load: active and shadow h/v steps = SCALE_STEP, inline_size = LINE_IN_SIZE_MAX, vs_q=0, state=IDLE, cfg_busy=0, cfg_err=0, cfg_upd=0, frame_cnt=0.
REQ-030 A reset asserted during PENDING SHALL discard the pending commit, and no load SHALL follow.

Configuration
REQ-031 With macro SCALER_CFG_CTRL_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 on every vs_rise, in any state, and SHALL wrap from 0xFFFF to 0x0000.
REQ-032 Without SCALER_CFG_CTRL_FRAME_CNT_EN, the frame_cnt port SHALL remain present and be tied to 0, with no counter logic.

Verification
REQ-033 The bench SHALL check: after reset, with no writes, outputs = 4096/4096/1024 and cfg_busy=0.
REQ-034 The bench SHALL check: write h=2048, v=8192, size=640, commit, then vs rise -> cfg_busy=1 until the load; outputs = 2048/8192/640 one clock after vs_rise; cfg_upd pulses once.
REQ-035 The bench SHALL check: commit with size=1025 -> cfg_err=1, state IDLE, outputs unchanged; a following valid commit clears cfg_err.
REQ-036 The bench SHALL check: during PENDING, write h=100 and commit again -> ignored; the load uses the earlier shadow values.
REQ-037 The bench SHALL check: commit coincident with vs_rise -> no load on that edge; the load occurs on the next vs_rise.
REQ-038 The bench SHALL check: with the macro defined, 65537 vs pulses -> frame_cnt=1; assert rst_n=0 mid-PENDING -> the next vs_rise gives no cfg_upd.
